// File: rtl/gray_counter_if.sv
// gray_counter_if: groups the control strobes, Gray load value and the
// registered binary/Gray/wrap outputs of the Gray-code counter.
// The master side drives the controls and observes the outputs.
// The slave side is the counter itself.
interface gray_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;

    modport master (
        output en,
        output up_dn,
        output load,
        output load_gray,
        input  bin_out,
        input  gray_out,
        input  wrap
    );

    modport slave (
        input  en,
        input  up_dn,
        input  load,
        input  load_gray,
        output bin_out,
        output gray_out,
        output wrap
    );

endinterface

// File: rtl/gray_counter.sv
// gray_counter: registered WIDTH-bit up/down counter with binary and Gray
// outputs, a Gray-coded parallel load and a one-cycle boundary pulse.
// Intended as a pointer/sequence source for CDC FIFOs and position encoders.
//
// Build option GRAY_COUNTER_SATURATE_EN: when defined, a step past either
// end of the range is suppressed and the count holds at the limit, with
// wrap pulsing for every suppressed step. When undefined the counter wraps
// modulo 2^WIDTH.
//
// gray_out is its own flop, loaded with the Gray encoding of the next binary
// value, so a consumer in another clock domain never sees a combinational
// glitch on it.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    gray_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] step_bin;
    logic             at_max;
    logic             at_min;
    logic             boundary;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: adjacent binary values differ in exactly one Gray bit.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Decode the load value and work out the candidate step and whether it crosses a boundary.
    always_comb begin
        load_bin = gray_to_bin(bus.load_gray);
        at_max   = (bin_q == ALL_ONES);
        at_min   = (bin_q == ZERO);
        step_bin = bus.up_dn ? (bin_q + ONE) : (bin_q - ONE);
        boundary = bus.en && (bus.up_dn ? at_max : at_min);
    end

    // Select the next register contents with load taking priority over counting.
    always_comb begin
        next_bin  = bin_q;
        next_gray = gray_q;
        next_wrap = 1'b0;
        if (bus.load) begin
            next_bin  = load_bin;
            next_gray = bus.load_gray;
            next_wrap = 1'b0;
        end else if (bus.en) begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (boundary) begin
                next_bin = bin_q;
            end else begin
                next_bin = step_bin;
            end
`else
            next_bin = step_bin;
`endif
            next_gray = bin_to_gray(next_bin);
            next_wrap = boundary;
        end
    end

    // Count, Gray and wrap registers, cleared together by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= next_gray;
            wrap_q <= next_wrap;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed scenarios followed by randomized traffic, all
// checked against a count-level reference model kept in this bench.
module tb_gray_counter;

    localparam int WIDTH = 4;
    localparam int MAX   = (1 << WIDTH) - 1;

    logic clk;
    logic rst;

    gray_counter_if #(.WIDTH(WIDTH)) bus ();

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors;
    int miscompares;

    int   model_count;
    logic model_wrap;
    logic model_stepped;
    logic [WIDTH-1:0] prev_gray;

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int gray_of(input int n);
        return n ^ (n >> 1);
    endfunction

    // Find the position whose Gray code matches g by searching the whole range.
    function automatic int index_of_gray(input logic [WIDTH-1:0] g);
        for (int k = 0; k <= MAX; k++) begin
            if (gray_of(k) == int'(g)) return k;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input logic r, input logic l, input logic e, input logic u,
                             input logic [WIDTH-1:0] g);
        model_stepped = 1'b0;
        if (r) begin
            model_count = 0;
            model_wrap  = 1'b0;
        end else if (l) begin
            model_count = index_of_gray(g);
            model_wrap  = 1'b0;
        end else if (e) begin
            if (u && model_count == MAX) begin
                model_wrap = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
                model_count   = 0;
                model_stepped = 1'b1;
`endif
            end else if (!u && model_count == 0) begin
                model_wrap = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
                model_count   = MAX;
                model_stepped = 1'b1;
`endif
            end else begin
                model_count   = u ? model_count + 1 : model_count - 1;
                model_wrap    = 1'b0;
                model_stepped = 1'b1;
            end
        end else begin
            model_wrap = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic e, input logic u,
                                 input logic [WIDTH-1:0] g);
        rst           = r;
        bus.load      = l;
        bus.en        = e;
        bus.up_dn     = u;
        bus.load_gray = g;
        prev_gray     = bus.gray_out;
        @(posedge clk);
        #1;
        modelStep(r, l, e, u, g);
        checkOutput("bin_out",  32'(bus.bin_out),  32'(model_count));
        checkOutput("gray_out", 32'(bus.gray_out), 32'(gray_of(model_count)));
        checkOutput("wrap",     32'(bus.wrap),     32'(model_wrap));
        if (model_stepped) begin
            checkOutput("hamming", 32'($countones(prev_gray ^ bus.gray_out)), 32'd1);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        model_count   = 0;
        model_wrap    = 1'b0;
        model_stepped = 1'b0;
        prev_gray     = '0;
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.en        = 1'b0;
        bus.up_dn     = 1'b1;
        bus.load_gray = '0;

        // Reset, then a full up-sweep through all 16 codes and back to zero.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        checkOutput("reset_gray", 32'(bus.gray_out), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        end

        // Down-step from zero.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);

        // Gray load wins over enable, then one up-step.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101);
        checkOutput("load_bin_const",  32'(bus.bin_out),  32'b1001);
        checkOutput("load_gray_const", 32'(bus.gray_out), 32'b1101);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        checkOutput("after_load_bin",  32'(bus.bin_out),  32'b1010);
        checkOutput("after_load_gray", 32'(bus.gray_out), 32'b1111);

        // From 0101: up, up, down, hold, down.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0111);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("dir_seq_end", 32'(bus.bin_out), 32'b0101);

        // Reset beats load and enable at count 1010.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);

        // Push into the top limit three times, then step back down.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);

        // Push into the bottom limit on consecutive cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);

        // Randomized traffic with occasional reset and load.
        for (int i = 0; i < 400; i++) begin
            logic r, l, e, u;
            logic [WIDTH-1:0] g;
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 3) != 0) ^ (i >= 200);
            g = WIDTH'($urandom);
            applyStimulus(r, l, e, u, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
